// File: rtl/ecc_enc_stream_pkg.sv
// Shared types and SECDED helper functions for the streaming encoder.
package ecc_pkg;

  // Widest information word the encode helper supports (m = 7, CW = 72).
  localparam int MAX_K  = 64;
  localparam int MAX_CW = 72;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'd0,
    INJ_SINGLE = 2'd1,
    INJ_DOUBLE = 2'd2,
    INJ_RSVD   = 2'd3
  } inj_mode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Smallest m with 2^m >= m + k + 1.
  function automatic int calc_m(input int k);
    int m;
    m = 32'sd1;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << m) < (m + k + 32'sd1)) begin
        m = m + 32'sd1;
      end
    end
    return m;
  endfunction

  // Extended Hamming codeword of the low k bits of d; only the low
  // calc_m(k)+k+1 bits of the result are meaningful.
  function automatic logic [MAX_CW-1:0] ecc_encode(input logic [MAX_K-1:0] d,
                                                   input int k,
                                                   input logic p0_lsb);
    logic [MAX_CW-1:0] pos;
    logic [MAX_CW-1:0] cw;
    logic              p;
    logic              p0;
    int                m;
    int                n;
    int                di;
    int                q;
    pos = '0;
    cw  = '0;
    p0  = 1'b0;
    m   = calc_m(k);
    n   = m + k;
    di  = 32'sd0;
    // Information bits fill the non-power-of-2 positions in ascending order.
    for (int i = 1; i < MAX_CW; i++) begin
      if ((i <= n) && ((i & (i - 32'sd1)) != 32'sd0)) begin
        pos[i[6:0]] = d[di[5:0]];
        di = di + 32'sd1;
      end
    end
    // Parity p_(j+1) at position 2^j covers every position with bit j set.
    for (int j = 0; j < 7; j++) begin
      if (j < m) begin
        p = 1'b0;
        for (int i = 1; i < MAX_CW; i++) begin
          if ((i <= n) && (((i >> j) & 32'sd1) != 32'sd0)) begin
            p = p ^ pos[i[6:0]];
          end
        end
        q = 32'sd1 << j;
        pos[q[6:0]] = p;
      end
    end
    // Overall parity over positions 1..n.
    for (int i = 1; i < MAX_CW; i++) begin
      if (i <= n) begin
        p0 = p0 ^ pos[i[6:0]];
      end
    end
    if (p0_lsb) begin
      cw    = pos;
      cw[0] = p0;
    end else begin
      cw          = pos >> 1;
      cw[n[6:0]]  = p0;
    end
    return cw;
  endfunction

endpackage

// File: rtl/ecc_enc_stream_if.sv
// Producer/consumer handshake bundle of the streaming SECDED encoder.
interface ecc_enc_stream_if #(
  parameter int K     = 8,
  parameter int LANES = 1
);
  import ecc_pkg::*;

  localparam int CW = calc_m(K) + K + 1;
  localparam int PW = $clog2(CW + 1);

  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [LANES*K-1:0]    s_data_i;
  logic [1:0]            inj_mode_i;
  logic [PW-1:0]         inj_pos_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [LANES*CW-1:0]   m_data_o;

  modport slave (
    input  s_valid_i, s_data_i, inj_mode_i, inj_pos_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o
  );

  modport master (
    output s_valid_i, s_data_i, inj_mode_i, inj_pos_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o
  );

endinterface

// File: rtl/ecc_enc.sv
// Combinational single-lane extended Hamming encoder.
module ecc_enc
  import ecc_pkg::*;
#(
  parameter int   K      = 8,
  parameter bit   P0_LSB = 1'b1,
  localparam int  CW     = calc_m(K) + K + 1
) (
  input  logic [K-1:0]  i_data,
  output logic [CW-1:0] o_cw
);

  assign o_cw = CW'(ecc_encode(MAX_K'(i_data), K, P0_LSB));

endmodule

// File: rtl/ecc_enc_stream.sv
// Multi-lane SECDED encoder with error injection, a registered output
// stage backed by a one-entry skid register, and an accepted-beat counter.
module ecc_enc_stream
  import ecc_pkg::*;
#(
  parameter int K      = 8,
  parameter int LANES  = 1,
  parameter bit P0_LSB = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ecc_enc_stream_if.slave   bus,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam int CW = calc_m(K) + K + 1;

  logic [LANES*CW-1:0] w_cw;
  logic [LANES*CW-1:0] w_inj;
  logic [CW-1:0]       w_mask;
  logic [LANES*CW-1:0] r_out;
  logic [LANES*CW-1:0] r_skid;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ready;
  state_t              r_state;
  state_t              w_next;
  inj_mode_t           w_mode;
  int                  w_pos;
  int                  w_pos2;
  logic                w_accept;
  logic                w_consume;
  logic                w_load_out;
  logic                w_load_skid;
  logic                w_skid_to_out;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ecc_enc #(.K(K), .P0_LSB(P0_LSB)) u_enc (
      .i_data (bus.s_data_i[g*K +: K]),
      .o_cw   (w_cw[g*CW +: CW])
    );
  end

  assign w_mode = inj_mode_t'(bus.inj_mode_i);
  assign w_pos  = int'(bus.inj_pos_i);
  // An out-of-range first index keeps the second index out of range too.
  assign w_pos2 = (w_pos == (CW - 1)) ? 32'sd0 : (w_pos + 32'sd1);

  // Build the per-lane flip mask for the current injection request.
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < CW; b++) begin
      case (w_mode)
        INJ_SINGLE: w_mask[b] = (b == w_pos);
        INJ_DOUBLE: w_mask[b] = (b == w_pos) || (b == w_pos2);
        default:    w_mask[b] = 1'b0;
      endcase
    end
  end

  assign w_inj     = w_cw ^ {LANES{w_mask}};
  assign w_accept  = bus.s_valid_i & r_ready;
  assign w_consume = (r_state != ST_EMPTY) & bus.m_ready_i;

  // Next-state and datapath load strobes of the OUT/SKID pair.
  always_comb begin
    w_next        = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_out = 1'b1;
          w_next     = ST_ONE;
        end else begin
          w_next     = ST_EMPTY;
        end
      end
      ST_ONE: begin
        case ({w_accept, w_consume})
          2'b11:   w_load_out  = 1'b1;
          2'b01:   w_next      = ST_EMPTY;
          2'b10: begin
            w_load_skid = 1'b1;
            w_next      = ST_FULL;
          end
          default: w_next      = ST_ONE;
        endcase
      end
      ST_FULL: begin
        if (w_consume) begin
          w_skid_to_out = 1'b1;
          w_next        = ST_ONE;
        end else begin
          w_next        = ST_FULL;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  // Control state, registered ready and the wrapping beat counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next != ST_FULL);
      if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // OUT and SKID codeword storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out) begin
        r_out <= w_inj;
      end else if (w_skid_to_out) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_inj;
      end
    end
  end

  assign bus.s_ready_o = r_ready;
  assign bus.m_valid_o = (r_state != ST_EMPTY);
  assign bus.m_data_o  = r_out;
  assign cnt_o         = r_cnt;

endmodule

// File: tb/tb_ecc_enc_stream.sv
// Scoreboard bench: a single-lane instance (p0 at bit 0, 4-bit counter) for
// the directed vectors and a four-lane instance (p0 at bit n) for random
// traffic, both checked against a syndrome-based reference encoder.
module tb_ecc_enc_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecc_enc_stream_if #(.K(8), .LANES(1)) bus_a ();
  ecc_enc_stream_if #(.K(8), .LANES(4)) bus_b ();
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  ecc_enc_stream #(.K(8), .LANES(1), .P0_LSB(1'b1), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a.slave), .cnt_o(cnt_a));
  ecc_enc_stream #(.K(8), .LANES(4), .P0_LSB(1'b0), .CNT_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b.slave), .cnt_o(cnt_b));

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] q_a[$];
  logic [51:0] q_b[$];
  bit          stall_a = 1'b0;
  bit          stall_b = 1'b0;
  logic [12:0] hold_a;
  logic [51:0] hold_b;
  int          b_seen  = 0;
  int          b_gaps  = 0;
  bit          b_gap_en = 1'b0;
  bit          b_done  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: place data, then choose the parity bits so that the XOR of
  // the indices of all set positions is zero; p0 makes total parity even.
  function automatic logic [12:0] ref_encode(input logic [7:0] d, input logic [1:0] mode,
                                             input int pos, input bit p0lsb);
    bit          bits[13];
    int          syn;
    int          di;
    bit          p0;
    logic [12:0] cw;
    syn = 0; di = 0; p0 = 1'b0; cw = '0;
    for (int i = 0; i < 13; i++) bits[i] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if ((i & (i - 1)) != 0) begin
        bits[i] = d[di];
        if (d[di]) syn = syn ^ i;
        di++;
      end
    end
    for (int j = 0; j < 4; j++) bits[1 << j] = syn[j];
    for (int i = 1; i <= 12; i++) p0 = p0 ^ bits[i];
    if (p0lsb) begin
      cw[0] = p0;
      for (int i = 1; i <= 12; i++) cw[i] = bits[i];
    end else begin
      for (int i = 1; i <= 12; i++) cw[i-1] = bits[i];
      cw[12] = p0;
    end
    if (pos < 13) begin
      if (mode == 2'd1) begin
        cw[pos] = ~cw[pos];
      end else if (mode == 2'd2) begin
        cw[pos] = ~cw[pos];
        cw[(pos + 1) % 13] = ~cw[(pos + 1) % 13];
      end
    end
    return cw;
  endfunction

  // Monitor A: compare consumed beats, check hold under stall, log accepts.
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("a_hold_valid", bus_a.m_valid_o, 1);
        check("a_hold_data", bus_a.m_data_o, hold_a);
      end
      if (bus_a.m_valid_o && bus_a.m_ready_i) begin
        check("a_sb_nonempty", (q_a.size() > 0), 1);
        if (q_a.size() > 0) check("a_sb_data", bus_a.m_data_o, q_a.pop_front());
      end
      stall_a = bus_a.m_valid_o && !bus_a.m_ready_i;
      hold_a  = bus_a.m_data_o;
      if (bus_a.s_valid_i && bus_a.s_ready_o)
        q_a.push_back(ref_encode(bus_a.s_data_i, bus_a.inj_mode_i, int'(bus_a.inj_pos_i), 1'b1));
    end
  end

  // Monitor B: same checks per four-lane beat, plus gap counting.
  always @(negedge clk) begin
    logic [51:0] e;
    if (rst) begin
      q_b.delete();
      stall_b = 1'b0;
    end else begin
      if (b_gap_en && b_seen > 0 && b_seen < 100 && !bus_b.m_valid_o) b_gaps++;
      if (stall_b) begin
        check("b_hold_valid", bus_b.m_valid_o, 1);
        check("b_hold_data", bus_b.m_data_o, hold_b);
      end
      if (bus_b.m_valid_o && bus_b.m_ready_i) begin
        b_seen++;
        check("b_sb_nonempty", (q_b.size() > 0), 1);
        if (q_b.size() > 0) check("b_sb_data", bus_b.m_data_o, q_b.pop_front());
      end
      stall_b = bus_b.m_valid_o && !bus_b.m_ready_i;
      hold_b  = bus_b.m_data_o;
      if (bus_b.s_valid_i && bus_b.s_ready_o) begin
        for (int l = 0; l < 4; l++)
          e[l*13 +: 13] = ref_encode(bus_b.s_data_i[l*8 +: 8], bus_b.inj_mode_i,
                                     int'(bus_b.inj_pos_i), 1'b0);
        q_b.push_back(e);
      end
    end
  end

  task automatic send_a(input logic [7:0] d, input logic [1:0] mode, input logic [3:0] pos);
    bit done = 1'b0;
    bus_a.s_data_i = d; bus_a.inj_mode_i = mode; bus_a.inj_pos_i = pos;
    bus_a.s_valid_i = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (bus_a.s_ready_o) done = 1'b1;
      @(posedge clk); #1;
    end
    bus_a.s_valid_i = 1'b0;
    check("a_accept", done, 1);
  endtask

  task automatic send_b(input logic [31:0] d, input logic [1:0] mode, input logic [3:0] pos);
    bit done = 1'b0;
    bus_b.s_data_i = d; bus_b.inj_mode_i = mode; bus_b.inj_pos_i = pos;
    bus_b.s_valid_i = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (bus_b.s_ready_o) done = 1'b1;
      @(posedge clk); #1;
    end
    bus_b.s_valid_i = 1'b0;
    check("b_accept", done, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.s_valid_i = 1'b0; bus_a.s_data_i = '0; bus_a.inj_mode_i = '0;
    bus_a.inj_pos_i = '0;   bus_a.m_ready_i = 1'b0;
    bus_b.s_valid_i = 1'b0; bus_b.s_data_i = '0; bus_b.inj_mode_i = '0;
    bus_b.inj_pos_i = '0;   bus_b.m_ready_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_valid", bus_a.m_valid_o, 0);
    check("rst_ready", bus_a.s_ready_o, 1);
    check("rst_cnt", cnt_a, 0);
    check("rst_data", bus_a.m_data_o, 0);
    check("rst_b_ready", bus_b.s_ready_o, 1);
    check("rst_b_cnt", cnt_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed encodes and injections, downstream always ready.
    bus_a.m_ready_i = 1'b1;
    send_a(8'hFF, 2'd0, 4'd0);  check("enc_ff", bus_a.m_data_o, 13'h1EEE);
    check("lat_valid", bus_a.m_valid_o, 1);
    send_a(8'h01, 2'd0, 4'd0);  check("enc_01", bus_a.m_data_o, 13'h000F);
    send_a(8'h00, 2'd0, 4'd0);  check("enc_00", bus_a.m_data_o, 13'h0000);
    send_a(8'h00, 2'd1, 4'd0);  check("inj_single0", bus_a.m_data_o, 13'h0001);
    send_a(8'h00, 2'd2, 4'd12); check("inj_double_wrap", bus_a.m_data_o, 13'h1001);
    send_a(8'h00, 2'd1, 4'd13); check("inj_out_of_range", bus_a.m_data_o, 13'h0000);
    send_a(8'hFF, 2'd3, 4'd2);  check("inj_reserved", bus_a.m_data_o, 13'h1EEE);
    @(posedge clk); #1;
    check("drain_valid", bus_a.m_valid_o, 0);

    // Backpressure fills OUT then SKID, then drains in order.
    bus_a.m_ready_i = 1'b0;
    send_a(8'h01, 2'd0, 4'd0);  check("bp_ready_one", bus_a.s_ready_o, 1);
    send_a(8'hFF, 2'd0, 4'd0);  check("bp_ready_full", bus_a.s_ready_o, 0);
    check("bp_data_full", bus_a.m_data_o, 13'h000F);
    @(posedge clk); #1;
    check("bp_hold", bus_a.m_data_o, 13'h000F);
    check("bp_still_full", bus_a.s_ready_o, 0);
    bus_a.m_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_second", bus_a.m_data_o, 13'h1EEE);
    check("bp_ready_back", bus_a.s_ready_o, 1);
    @(posedge clk); #1;
    check("bp_empty", bus_a.m_valid_o, 0);
    check("cnt_nine", cnt_a, 4'd9);

    // Reset while FULL discards both entries.
    bus_a.m_ready_i = 1'b0;
    send_a(8'($urandom), 2'd0, 4'd0);
    send_a(8'($urandom), 2'd0, 4'd0);
    check("full_before_rst", bus_a.s_ready_o, 0);
    rst = 1'b1;
    #1;
    check("rst_async_valid", bus_a.m_valid_o, 0);
    check("rst_async_ready", bus_a.s_ready_o, 1);
    check("rst_async_cnt", cnt_a, 0);
    @(posedge clk); #1;
    check("rst_edge_valid", bus_a.m_valid_o, 0);
    check("rst_edge_cnt", cnt_a, 0);
    rst = 1'b0;
    bus_a.m_ready_i = 1'b1;
    send_a(8'hFF, 2'd0, 4'd0);  check("post_rst_enc", bus_a.m_data_o, 13'h1EEE);
    check("post_rst_cnt", cnt_a, 4'd1);

    // Counter wrap on the 4-bit instance.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 17; i++)
      send_a(8'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    @(posedge clk); #1;
    check("cnt_wrap", cnt_a, 4'd1);

    // Four lanes, full-rate random traffic.
    bus_b.m_ready_i = 1'b1;
    b_gap_en = 1'b1;
    for (int i = 0; i < 100; i++)
      send_b($urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    repeat (3) @(posedge clk); #1;
    b_gap_en = 1'b0;
    check("b_cnt_100", cnt_b, 100);
    check("b_seen_100", b_seen, 100);
    check("b_no_gaps", b_gaps, 0);
    check("b_sb_drained", q_b.size(), 0);

    // Four lanes, random idles and random downstream stalls.
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_b($urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        b_done = 1'b1;
      end
      begin
        while (!b_done) begin
          @(posedge clk); #1;
          bus_b.m_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus_b.m_ready_i = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("b_cnt_200", cnt_b, 200);
    check("b_seen_200", b_seen, 200);
    check("b_sb_drained2", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_enc_stream.md
# ecc_enc_stream

Streaming, multi-lane extended-Hamming (SECDED) encoder with a valid/ready handshake, one registered output stage backed by a skid buffer, and built-in error injection for downstream decoder test. Each accepted beat carries LANES independent K-bit information words. Each word is encoded to an (n+1)-bit codeword. The block sits between a data producer and a memory or link write port, and replaces bare combinational encoding where timing closure or backpressure is needed.

## Interface
- K, 8: information bits per lane, at least 1.
- LANES, 1: number of words per beat, at least 1.
- P0_LSB, 1: 1 places p0 at codeword bit 0; 0 places p0 at bit n.
- CNT_W, 32: width of the beat counter.
- Derived, not overridable: m = smallest m with 2^m >= m+K+1; n = m+K; CW = n+1.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- s_valid_i  in  1  input beat valid.
- s_ready_o  out  1  block can accept a beat.
- s_data_i  in  LANES*K  information words; lane j occupies bits [j*K +: K].
- inj_mode_i  in  2  error injection mode, sampled with the beat: 0 none, 1 single flip, 2 double flip, 3 reserved (treated as none).
- inj_pos_i  in  $clog2(CW+1)  codeword bit index of the first flip.
- m_valid_o  out  1  output beat valid.
- m_ready_i  in  1  downstream accepts the output beat.
- m_data_o  out  LANES*CW  codewords; lane j occupies bits [j*CW +: CW].
- cnt_o  out  CNT_W  number of accepted input beats.

## Operation
- Input handshake: a beat is accepted when s_valid_i && s_ready_o. Output handshake: a beat is consumed when m_valid_o && m_ready_i.
- Each lane is encoded the same way:
  - Information bits go to the non-power-of-2 positions 1..n, in ascending order.
  - Parity bit p_i sits at position 2^(i-1) and is the XOR of every position whose index has bit i-1 set.
  - p0 is the XOR of positions 1..n.
- Injection is applied after encoding, identically in every lane, using the values sampled on the accepting edge:
  - Mode 1 inverts bit inj_pos_i.
  - Mode 2 inverts bits inj_pos_i and (inj_pos_i+1) mod CW.
  - If inj_pos_i >= CW, nothing is inverted in either mode.
- Storage is two entries: the output register (OUT) and the skid register (SKID). Control states are EMPTY, ONE and FULL.
  - EMPTY: an accepted beat loads OUT, next state ONE.
  - ONE, with accept and consume: OUT is reloaded, state stays ONE.
  - ONE, consume only: next state EMPTY.
  - ONE, accept only: the beat loads SKID, next state FULL.
  - FULL, consume: SKID moves to OUT, next state ONE. No accept is possible in FULL.
- s_ready_o = !(state == FULL), driven from a register. m_valid_o = (state != EMPTY).
- cnt_o increments by 1 on every accepted beat and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values: m_valid_o = 0, m_data_o = 0, cnt_o = 0, s_ready_o = 1, state EMPTY, SKID = 0.
- Latency: a beat accepted at edge t appears on m_data_o after edge t, so m_valid_o is high in cycle t+1 when OUT was empty or consumed at t.
- Sustained throughput is 1 beat per cycle while m_ready_i is held high.
- While m_valid_o && !m_ready_i, m_data_o must hold stable.
- Data order is strictly FIFO. No beat is dropped or duplicated.
- Simultaneous accept and consume in ONE leaves the state unchanged.
- Reset asserted mid-stream clears all entries immediately. In-flight beats are discarded, and cnt_o returns to 0.
- s_ready_o never depends combinationally on m_ready_i.

## Structure
- Package ecc_pkg holds:
  - function calc_m(k);
  - function ecc_encode(d, p0_lsb), returning the CW-bit codeword;
  - typedef enum inj_mode_t {INJ_NONE, INJ_SINGLE, INJ_DOUBLE, INJ_RSVD};
  - typedef enum for the EMPTY, ONE and FULL states.
- One sub-module, ecc_enc, is instantiated once per lane in a generate loop. It takes K and P0_LSB and provides the combinational codeword.
- Injection, the skid/output control and the counter are implemented in this block.

## Test plan
- K=8, LANES=1, P0_LSB=1, inj none, s_data_i=8'hFF -> one cycle later m_data_o=13'h1EEE. s_data_i=8'h01 -> 13'h00F. s_data_i=8'h00 -> 13'h000.
- Injection on s_data_i=8'h00: mode 1, pos 0 -> 13'h001. Mode 2, pos 12 (wrap) -> 13'h1001. Mode 1, pos 13 (out of range) -> 13'h000.
- Backpressure:
  - Send 8'h01 then 8'hFF back-to-back with m_ready_i=0 -> s_ready_o falls after the second accept, and m_data_o holds 13'h00F.
  - Raise m_ready_i -> 13'h00F then 13'h1EEE in consecutive cycles, and s_ready_o returns to 1.
- LANES=4, m_ready_i=1, 100 random beats -> every lane matches the reference model, there are no gaps after the first output, and cnt_o=100.
- CNT_W=4, 17 accepted beats -> cnt_o=1, showing the wrap.
- Assert rst_i while FULL -> m_valid_o=0, s_ready_o=1 and cnt_o=0 on the next edge. A subsequent beat encodes correctly.
